// File: rtl/decode_pkg.sv
// Shared instruction definitions for the decode stage.
// Field positions, widths and opecode constants.
package decode_pkg;

    localparam int LEN_OPECODE = 7;
    localparam int LEN_IMMF    = 1;
    localparam int LEN_CC      = 4;
    localparam int LEN_REG     = 32;
    localparam int LEN_IMM_EX  = 32;
    localparam int LEN_REGADDR = 4;
    localparam int LEN_INSN    = 32;
    localparam int LEN_IMM     = 16;
    localparam int NUM_REGS    = 1 << LEN_REGADDR;

    localparam int POS_OPECODE = 25;
    localparam int POS_IMMF    = 24;
    localparam int POS_CC      = 20;
    localparam int POS_RD      = 16;
    localparam int POS_RS      = 12;
    localparam int POS_IMM     = 0;

    localparam logic [LEN_OPECODE-1:0] OP_LD  = 7'b0011000;
    localparam logic [LEN_OPECODE-1:0] OP_ST  = 7'b0011001;
    localparam logic [LEN_OPECODE-1:0] OP_J   = 7'b0011010;
    localparam logic [LEN_OPECODE-1:0] OP_JA  = 7'b0011011;
    localparam logic [LEN_OPECODE-1:0] OP_CMP = 7'b0000100;
    localparam logic [LEN_OPECODE-1:0] OP_NOP = 7'b1111110;
    localparam logic [LEN_OPECODE-1:0] OP_HLT = 7'b1111111;

    function automatic logic writes_rd(input logic [LEN_OPECODE-1:0] op);
        return !(op inside {OP_ST, OP_J, OP_JA, OP_CMP, OP_NOP, OP_HLT});
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 16x32 register file: two async read ports, one sync write port.
// Synchronous active-low reset clears every register.
module decode_regfile
    import decode_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [LEN_REGADDR-1:0] wa,
    input  logic [LEN_REG-1:0]     wd,
    input  logic [LEN_REGADDR-1:0] ra0,
    input  logic [LEN_REGADDR-1:0] ra1,
    output logic [LEN_REG-1:0]     rd0,
    output logic [LEN_REG-1:0]     rd1
);

    logic [LEN_REG-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd0 = regs[ra0];
    assign rd1 = regs[ra1];

endmodule

// File: rtl/decode.sv
// Decode stage: field extraction, operand read with bypass, load-use stall.
// Define DECODE_FWD_EN to forward execute results instead of stalling on them.
module decode
    import decode_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   stall_o,
    input  logic [LEN_INSN-1:0]    insn,
    output logic                   valid_o,
    input  logic                   stall_i,
    output logic [LEN_OPECODE-1:0] opecode,
    output logic                   immf,
    output logic [LEN_CC-1:0]      cc,
    output logic [LEN_REG-1:0]     data_rd,
    output logic [LEN_REG-1:0]     data_rs,
    output logic [LEN_IMM_EX-1:0]  imm_ex,
    output logic [LEN_REGADDR-1:0] rd_addr_o,
    output logic                   wr_o,
    input  logic                   ex_valid,
    input  logic                   ex_wr,
    input  logic                   ex_ld,
    input  logic [LEN_REGADDR-1:0] ex_addr,
    input  logic [LEN_REG-1:0]     ex_data,
    input  logic                   wb_we,
    input  logic [LEN_REGADDR-1:0] wb_addr,
    input  logic [LEN_REG-1:0]     wb_data
);

    logic [LEN_OPECODE-1:0] f_op;
    logic                   f_immf;
    logic [LEN_CC-1:0]      f_cc;
    logic [LEN_REGADDR-1:0] f_rd;
    logic [LEN_REGADDR-1:0] f_rs;
    logic [LEN_IMM-1:0]     f_imm;
    logic [LEN_IMM_EX-1:0]  f_imm_ex;
    logic [LEN_REG-1:0]     rf_rd;
    logic [LEN_REG-1:0]     rf_rs;
    logic [LEN_REG-1:0]     rd_val;
    logic [LEN_REG-1:0]     rs_val;
    logic                   hit_rd;
    logic                   hit_rs;
    logic                   ld_haz;
    logic                   hazard;

    assign f_op     = insn[POS_OPECODE +: LEN_OPECODE];
    assign f_immf   = insn[POS_IMMF];
    assign f_cc     = insn[POS_CC +: LEN_CC];
    assign f_rd     = insn[POS_RD +: LEN_REGADDR];
    assign f_rs     = insn[POS_RS +: LEN_REGADDR];
    assign f_imm    = insn[POS_IMM +: LEN_IMM];
    assign f_imm_ex = {{(LEN_IMM_EX-LEN_IMM){f_imm[LEN_IMM-1]}}, f_imm};

    decode_regfile u_rf (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wa  (wb_addr),
        .wd  (wb_data),
        .ra0 (f_rd),
        .ra1 (f_rs),
        .rd0 (rf_rd),
        .rd1 (rf_rs)
    );

    assign hit_rd = ex_addr == f_rd;
    assign hit_rs = !f_immf && ex_addr == f_rs;
    assign ld_haz = ex_valid && ex_ld && (hit_rd || hit_rs);

`ifdef DECODE_FWD_EN
    logic fwd_ok;
    assign fwd_ok = ex_valid && ex_wr && !ex_ld;
    assign hazard = valid_i && ld_haz;
`else
    // Without forwarding any in-flight writer blocks until it reaches wb.
    logic unused_ex_data;
    assign unused_ex_data = ^ex_data;
    assign hazard = valid_i
                 && (ld_haz || (ex_valid && ex_wr && (hit_rd || hit_rs)));
`endif

    always_comb begin
        rd_val = rf_rd;
        rs_val = rf_rs;
        if (wb_we && wb_addr == f_rd) rd_val = wb_data;
        if (wb_we && wb_addr == f_rs) rs_val = wb_data;
`ifdef DECODE_FWD_EN
        if (fwd_ok && ex_addr == f_rd) rd_val = ex_data;
        if (fwd_ok && ex_addr == f_rs) rs_val = ex_data;
`endif
        if (f_immf) rs_val = f_imm_ex;
    end

    assign stall_o = rst && ((valid_o && stall_i) || hazard);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o   <= 1'b0;
            opecode   <= '0;
            immf      <= 1'b0;
            cc        <= '0;
            data_rd   <= '0;
            data_rs   <= '0;
            imm_ex    <= '0;
            rd_addr_o <= '0;
            wr_o      <= 1'b0;
        end else if (!stall_i) begin
            valid_o   <= valid_i && !hazard;
            opecode   <= f_op;
            immf      <= f_immf;
            cc        <= f_cc;
            data_rd   <= rd_val;
            data_rs   <= rs_val;
            imm_ex    <= f_imm_ex;
            rd_addr_o <= f_rd;
            wr_o      <= writes_rd(f_op);
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed testbench for the decode stage.
// Expectations follow DECODE_FWD_EN when the bench is built with it.
module tb_decode;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        stall_o;
    logic [31:0] insn;
    logic        valid_o;
    logic        stall_i;
    logic [6:0]  opecode;
    logic        immf;
    logic [3:0]  cc;
    logic [31:0] data_rd;
    logic [31:0] data_rs;
    logic [31:0] imm_ex;
    logic [3:0]  rd_addr_o;
    logic        wr_o;
    logic        ex_valid;
    logic        ex_wr;
    logic        ex_ld;
    logic [3:0]  ex_addr;
    logic [31:0] ex_data;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] OP_ADD = 7'b0000001;
    localparam logic [6:0] OP_SUB = 7'b0000010;

    decode dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .stall_o   (stall_o),
        .insn      (insn),
        .valid_o   (valid_o),
        .stall_i   (stall_i),
        .opecode   (opecode),
        .immf      (immf),
        .cc        (cc),
        .data_rd   (data_rd),
        .data_rs   (data_rs),
        .imm_ex    (imm_ex),
        .rd_addr_o (rd_addr_o),
        .wr_o      (wr_o),
        .ex_valid  (ex_valid),
        .ex_wr     (ex_wr),
        .ex_ld     (ex_ld),
        .ex_addr   (ex_addr),
        .ex_data   (ex_data),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] op,
                                         input logic [3:0] rd,
                                         input logic [3:0] rs);
        return {op, 1'b0, 4'h0, rd, rs, 12'h000};
    endfunction

    function automatic logic [31:0] mk_i(input logic [6:0] op,
                                         input logic [3:0] rd,
                                         input logic [15:0] imm);
        return {op, 1'b1, 4'h0, rd, imm};
    endfunction

    task automatic ex_idle();
        ex_valid = 1'b0;
        ex_wr    = 1'b0;
        ex_ld    = 1'b0;
        ex_addr  = 4'h0;
        ex_data  = 32'h0;
    endtask

    logic [6:0] ops [9];
    logic       wrs [9];

    initial begin
        ops = '{OP_ST, OP_J, OP_JA, OP_CMP, OP_NOP, OP_HLT,
                OP_ADD, OP_SUB, OP_LD};
        wrs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // reset with a load-use hazard pending: stall_o must stay low
        rst      = 1'b0;
        valid_i  = 1'b1;
        stall_i  = 1'b1;
        insn     = mk_r(OP_ADD, 4'd4, 4'd4);
        ex_valid = 1'b1;
        ex_wr    = 1'b1;
        ex_ld    = 1'b1;
        ex_addr  = 4'd4;
        ex_data  = 32'h0;
        wb_we    = 1'b1;
        wb_addr  = 4'd7;
        wb_data  = 32'hDEAD_BEEF;
        #2;
        check("rst_stall_o", {31'b0, stall_o}, 32'h0);
        step();
        check("rst_valid_o", {31'b0, valid_o}, 32'h0);
        check("rst_wr_o", {31'b0, wr_o}, 32'h0);
        check("rst_data_rd", data_rd, 32'h0);
        check("rst_opecode", {25'b0, opecode}, 32'h0);

        rst     = 1'b1;
        valid_i = 1'b0;
        stall_i = 1'b0;
        wb_we   = 1'b0;
        ex_idle();
        step();

        // write r3 then read it two cycles later
        wb_we   = 1'b1;
        wb_addr = 4'd3;
        wb_data = 32'h1234_5678;
        step();
        wb_we = 1'b0;
        step();
        valid_i = 1'b1;
        insn    = mk_r(OP_ADD, 4'd3, 4'd3);
        step();
        check("r3_valid_o", {31'b0, valid_o}, 32'h1);
        check("r3_data_rd", data_rd, 32'h1234_5678);
        check("r3_data_rs", data_rs, 32'h1234_5678);
        check("r3_wr_o", {31'b0, wr_o}, 32'h1);
        check("r3_rd_addr", {28'b0, rd_addr_o}, 32'd3);

        // wb bypass in the same cycle
        insn    = mk_r(OP_ADD, 4'd5, 4'd1);
        wb_we   = 1'b1;
        wb_addr = 4'd5;
        wb_data = 32'hA;
        step();
        check("wbbyp_data_rd", data_rd, 32'hA);
        check("wbbyp_data_rs", data_rs, 32'h0);

        // execute result on r2, wb writing stale r2 at the same time
        insn     = mk_r(OP_ADD, 4'd1, 4'd2);
        ex_valid = 1'b1;
        ex_wr    = 1'b1;
        ex_addr  = 4'd2;
        ex_data  = 32'h55;
        wb_addr  = 4'd2;
        wb_data  = 32'h99;
        #1;
`ifdef DECODE_FWD_EN
        check("fwd_stall_o", {31'b0, stall_o}, 32'h0);
        step();
        check("fwd_valid_o", {31'b0, valid_o}, 32'h1);
        check("fwd_data_rs", data_rs, 32'h55);
        ex_idle();
        wb_we = 1'b0;
`else
        check("nofwd_stall_o", {31'b0, stall_o}, 32'h1);
        step();
        check("nofwd_bubble", {31'b0, valid_o}, 32'h0);
        ex_idle();
        wb_data = 32'h55;
        #1;
        check("nofwd_release", {31'b0, stall_o}, 32'h0);
        step();
        check("nofwd_valid_o", {31'b0, valid_o}, 32'h1);
        check("nofwd_data_rs", data_rs, 32'h55);
        wb_we = 1'b0;
`endif

        // wr_o per opecode
        for (int i = 0; i < 9; i++) begin
            insn = mk_r(ops[i], 4'd0, 4'd0);
            step();
            check($sformatf("wr_o_op%0d", i), {31'b0, wr_o}, {31'b0, wrs[i]});
        end

        // load-use on r4 through rs
        insn     = mk_r(OP_ADD, 4'd1, 4'd4);
        ex_valid = 1'b1;
        ex_wr    = 1'b1;
        ex_ld    = 1'b1;
        ex_addr  = 4'd4;
        #1;
        check("ld_stall_o", {31'b0, stall_o}, 32'h1);
        step();
        check("ld_bubble", {31'b0, valid_o}, 32'h0);
        ex_idle();
        wb_we   = 1'b1;
        wb_addr = 4'd4;
        wb_data = 32'h44;
        #1;
        check("ld_release", {31'b0, stall_o}, 32'h0);
        step();
        check("ld_valid_o", {31'b0, valid_o}, 32'h1);
        check("ld_data_rs", data_rs, 32'h44);
        wb_we = 1'b0;

        // immediate form ignores the rs field for load-use
        insn     = mk_i(OP_ADD, 4'd1, 16'h4000);
        ex_valid = 1'b1;
        ex_wr    = 1'b1;
        ex_ld    = 1'b1;
        ex_addr  = 4'd4;
        #1;
        check("imm_no_haz", {31'b0, stall_o}, 32'h0);
        ex_idle();

        // negative immediate then a 3-cycle execute stall
        insn = mk_i(OP_ADD, 4'd5, 16'h8000);
        step();
        check("imm_ex_neg", imm_ex, 32'hFFFF_8000);
        check("imm_data_rs", data_rs, 32'hFFFF_8000);
        check("imm_data_rd", data_rd, 32'hA);
        check("imm_immf", {31'b0, immf}, 32'h1);
        stall_i = 1'b1;
        insn    = mk_i(OP_SUB, 4'd5, 16'h7FFF);
        wb_we   = 1'b1;
        wb_addr = 4'd5;
        wb_data = 32'hBB;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold_stall_o%0d", c), {31'b0, stall_o}, 32'h1);
            step();
            check($sformatf("hold_rs%0d", c), data_rs, 32'hFFFF_8000);
            check($sformatf("hold_rd%0d", c), data_rd, 32'hA);
            check($sformatf("hold_op%0d", c), {25'b0, opecode}, {25'b0, OP_ADD});
            check($sformatf("hold_v%0d", c), {31'b0, valid_o}, 32'h1);
        end
        wb_we   = 1'b0;
        stall_i = 1'b0;
        step();
        check("imm_ex_pos", imm_ex, 32'h0000_7FFF);
        check("rd_after_wb", data_rd, 32'hBB);

        // reset while stalled
        stall_i = 1'b1;
        rst     = 1'b0;
        #1;
        check("midrst_stall_o", {31'b0, stall_o}, 32'h0);
        step();
        check("midrst_valid_o", {31'b0, valid_o}, 32'h0);
        check("midrst_imm_ex", imm_ex, 32'h0);
        rst     = 1'b1;
        stall_i = 1'b0;
        for (int r = 0; r < 16; r++) begin
            insn = mk_r(OP_ADD, 4'(r), 4'(r));
            step();
            check($sformatf("clr_r%0d", r), data_rd, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
